inst_seq_ctrl: RTL and testbench
================================

# inst_seq_ctrl

Multi-cycle instruction sequencer for the NPC core. It issues fetches to instruction memory over a valid/ready handshake and latches the returned instruction for the decoder. It then steps the instruction through decode, execute and writeback, gating the register-file write enable and updating the PC. It halts on `ebreak` and sits between the instruction memory port and the idu/exu/register-file datapath.

## Interface
Parameters:
- `RESET_PC`, 64'h0000_0000_8000_0000, PC value loaded on reset.
- `EBREAK_INST`, 32'h0010_0073, encoding that halts the core.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rstn` in 1: reset, synchronous and active-low.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_addr` out 64: fetch address, equal to `pc`.
- `imem_rsp_valid` in 1: instruction data valid.
- `imem_rsp_data` in 32: returned instruction.
- `inst` out 32: latched instruction to idu.
- `inst_valid` out 1: high in DECODE, EXEC and WB.
- `reg_wr_req` in 1: idu reports that the instruction writes rd.
- `reg_wr_en` out 1: register-file write strobe.
- `pc_sel` in 1: exu requests a redirect.
- `next_pc` in 64: redirect target.
- `pc` out 64: current instruction address.
- `retire` out 1: one-cycle pulse per completed instruction.
- `instret` out 64: count of retired instructions.
- `halt` out 1: high once an `ebreak` has retired.

## Operation
- States: IDLE, FETCH, WAIT, DECODE, EXEC, WB, HALT.
- IDLE → FETCH unconditionally, one cycle after reset is released.
- FETCH: `imem_req_valid`=1 and `imem_addr`=`pc`.
  - Both are held stable until `imem_req_ready`=1.
  - On the handshake cycle, go to WAIT.
- WAIT: stay until `imem_rsp_valid`=1, then capture `imem_rsp_data` into `inst` and go to DECODE.
  - `imem_rsp_valid` in any other state is ignored.
  - `inst` is not modified outside WAIT.
- DECODE → EXEC → WB, each exactly one cycle.
- WB:
  - `reg_wr_en` = `reg_wr_req`. It is 0 in every other state.
  - `reg_wr_en` is forced to 0 when `inst` = `EBREAK_INST`.
  - `retire`=1 and `instret` increments by 1.
  - PC update: if `pc_sel`=1, `pc` ← {`next_pc`[63:2], 2'b00}; otherwise `pc` ← `pc`+4.
  - Next state: HALT if `inst` = `EBREAK_INST`, else FETCH.
- HALT: absorbing until reset. In HALT:
  - `halt`=1.
  - No requests are issued.
  - `pc` holds the `ebreak` address + 4.
  - `inst` and `instret` hold.
- PC arithmetic is 64-bit modulo 2^64: `pc`+4 from 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- `instret` wraps to 0 after all-ones.
- `pc_sel` and `next_pc` are sampled only in WB.
- `reg_wr_req` is sampled only in WB.

## Timing
- Reset (`rstn`=0 at a rising edge), applied in any state including mid-handshake:
  - state=IDLE, `pc`=`RESET_PC`, `inst`=0, `instret`=0.
  - All strobes (`imem_req_valid`, `inst_valid`, `reg_wr_en`, `retire`) = 0, `halt`=0.
  - An outstanding fetch is abandoned. The memory shares `rstn`, so no stale response arrives.
- The first `imem_req_valid` is high in the 2nd cycle after `rstn` rises.
- Minimum per-instruction latency is 5 cycles (FETCH, WAIT, DECODE, EXEC, WB), with `imem_req_ready`=1 immediately and response on the next cycle.
- Each cycle `imem_req_ready` is late adds 1 cycle. Each cycle `imem_rsp_valid` is late adds 1 cycle.
- The memory never asserts `imem_rsp_valid` in the same cycle as the request handshake.
- The cycle after WB is FETCH with the updated `pc`, so back-to-back instructions have 0 idle cycles.
- Moore outputs:
  - Registered: `pc`, `inst`, `instret`, `halt`.
  - Decoded from state: `imem_req_valid`, `inst_valid`.
  - `reg_wr_en` is state & `reg_wr_req`, with the same-cycle combinational input allowed.

## Test plan
- Reset, then `imem_req_ready`=1 and 1-cycle response with `addi x1,x0,5` (32'h0050_0093), `reg_wr_req`=1 in WB → `imem_addr`=0x8000_0000 in cycle 2; `reg_wr_en`=1 and `retire`=1 in cycle 6; `pc`=0x8000_0004; `instret`=1.
- `imem_req_ready` low for 3 cycles, then response delayed 2 cycles → `imem_req_valid` and `imem_addr` stable throughout; instruction takes 10 cycles; `imem_rsp_valid` pulses injected in DECODE/EXEC are ignored and `inst` is unchanged.
- `pc_sel`=1, `next_pc`=0x8000_0103 in WB → next fetch at 0x8000_0100.
- Fetch `EBREAK_INST` at 0x8000_0008 → `reg_wr_en`=0 in WB; `retire`=1 and `halt`=1 from the next cycle; `pc`=0x8000_000C; no further `imem_req_valid` for 20 cycles.
- Reset asserted in WAIT, then while in HALT → IDLE next cycle with `pc`=0x8000_0000, `instret`=0, `halt`=0; fetch resumes normally.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC, run one non-branch instruction → `pc` wraps to 0 and the second fetch address is 0.

Source files
------------

// File: rtl/inst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_seq_ctrl
// Purpose  : Multi-cycle instruction sequencer. Fetches one instruction at a
//            time over a valid/ready request and a response strobe, then
//            walks it through DECODE, EXEC and WB. WB gates the register-file
//            write and updates the PC. Stops in HALT after an ebreak retires.
// Ports    : clk, rstn              - clock, synchronous active-low reset
//            imem_req_valid/ready   - fetch request handshake
//            imem_addr              - fetch address (always equals pc)
//            imem_rsp_valid/data    - returned instruction
//            inst, inst_valid       - latched instruction for the decoder
//            reg_wr_req, reg_wr_en  - rd write request in, gated strobe out
//            pc_sel, next_pc        - redirect request and target from exu
//            pc, retire, instret    - PC, retire pulse, retired count
//            halt                   - set once an ebreak has retired
// Revision : 1.0 - initial release
// ============================================================================
module inst_seq_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        reg_wr_req,
    output logic        reg_wr_en,
    input  logic        pc_sel,
    input  logic [63:0] next_pc,
    output logic [63:0] pc,
    output logic        retire,
    output logic [63:0] instret,
    output logic        halt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    // Redirect targets are forced to a 4-byte boundary.
    localparam logic [63:0] c_align_mask = ~64'h3;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [63:0] r_pc;
    logic [31:0] r_inst;
    logic [63:0] r_instret;
    logic        r_halt;
    logic        w_is_ebreak;

    assign w_is_ebreak = (r_inst == EBREAK_INST);

    // Next-state and Moore/strobe outputs
    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        reg_wr_en      = 1'b0;
        retire         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                inst_valid  = 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                inst_valid  = 1'b1;
                w_state_nxt = S_WB;
            end
            S_WB: begin
                inst_valid  = 1'b1;
                retire      = 1'b1;
                // ebreak must never write the register file even if idu asks.
                reg_wr_en   = reg_wr_req & ~w_is_ebreak;
                w_state_nxt = w_is_ebreak ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and architectural state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= 32'd0;
            r_instret <= 64'd0;
            r_halt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_WAIT) && imem_rsp_valid) begin
                r_inst <= imem_rsp_data;
            end
            if (r_state == S_WB) begin
                r_instret <= r_instret + 64'd1;
                r_pc      <= pc_sel ? (next_pc & c_align_mask) : (r_pc + 64'd4);
                if (w_is_ebreak) begin
                    r_halt <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_inst;
    assign instret   = r_instret;
    assign halt      = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_inst_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_inst_seq_ctrl
// Purpose  : Self-checking bench for inst_seq_ctrl. An instruction-level
//            model plans every cycle of each transaction (fetch wait,
//            response wait, three pipeline steps) and publishes the expected
//            outputs; a single compare process checks them on the falling
//            edge. A second instance with RESET_PC at the top of the address
//            space runs in lock-step to exercise PC wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_seq_ctrl;

    localparam logic [63:0] c_reset_pc = 64'h0000_0000_8000_0000;
    localparam logic [63:0] c_wrap_pc  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] c_ebreak   = 32'h0010_0073;
    localparam logic [31:0] c_addi     = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        reg_wr_req = 1'b0;
    logic        pc_sel = 1'b0;
    logic [63:0] next_pc = '0;

    logic        imem_req_valid, inst_valid, reg_wr_en, retire, halt;
    logic [63:0] imem_addr, pc, instret;
    logic [31:0] inst;

    logic        wrap_req_valid, wrap_inst_valid, wrap_reg_wr_en, wrap_retire, wrap_halt;
    logic [63:0] wrap_addr, wrap_pc, wrap_instret;
    logic [31:0] wrap_inst;

    inst_seq_ctrl #(.RESET_PC(c_reset_pc), .EBREAK_INST(c_ebreak)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst(inst), .inst_valid(inst_valid),
        .reg_wr_req(reg_wr_req), .reg_wr_en(reg_wr_en), .pc_sel(pc_sel),
        .next_pc(next_pc), .pc(pc), .retire(retire), .instret(instret),
        .halt(halt)
    );

    inst_seq_ctrl #(.RESET_PC(c_wrap_pc), .EBREAK_INST(c_ebreak)) dut_wrap (
        .clk(clk), .rstn(rstn),
        .imem_req_valid(wrap_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(wrap_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst(wrap_inst), .inst_valid(wrap_inst_valid),
        .reg_wr_req(reg_wr_req), .reg_wr_en(wrap_reg_wr_en), .pc_sel(pc_sel),
        .next_pc(next_pc), .pc(wrap_pc), .retire(wrap_retire), .instret(wrap_instret),
        .halt(wrap_halt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model
    logic [63:0] m_pc, m_pc2, m_instret;
    logic [31:0] m_inst;
    logic        m_halt;

    // Expected outputs for the current cycle
    logic        exp_en = 1'b0;
    logic        exp_req_valid, exp_inst_valid, exp_reg_wr_en, exp_retire, exp_halt;
    logic [63:0] exp_pc, exp_pc2, exp_instret;
    logic [31:0] exp_inst;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_en) begin
            check("req_valid",  {63'd0, imem_req_valid}, {63'd0, exp_req_valid});
            check("imem_addr",  imem_addr,               exp_pc);
            check("pc",         pc,                      exp_pc);
            check("inst",       {32'd0, inst},           {32'd0, exp_inst});
            check("inst_valid", {63'd0, inst_valid},     {63'd0, exp_inst_valid});
            check("reg_wr_en",  {63'd0, reg_wr_en},      {63'd0, exp_reg_wr_en});
            check("retire",     {63'd0, retire},         {63'd0, exp_retire});
            check("instret",    instret,                 exp_instret);
            check("halt",       {63'd0, halt},           {63'd0, exp_halt});
            check("wrap_pc",    wrap_pc,                 exp_pc2);
            check("wrap_addr",  wrap_addr,               exp_pc2);
            check("wrap_req_valid", {63'd0, wrap_req_valid}, {63'd0, exp_req_valid});
            check("wrap_retire",    {63'd0, wrap_retire},    {63'd0, exp_retire});
            check("wrap_reg_wr_en", {63'd0, wrap_reg_wr_en}, {63'd0, exp_reg_wr_en});
            check("wrap_halt",      {63'd0, wrap_halt},      {63'd0, exp_halt});
            check("wrap_instret",   wrap_instret,            exp_instret);
            check("wrap_inst",      {32'd0, wrap_inst},      {32'd0, exp_inst});
            check("wrap_inst_valid", {63'd0, wrap_inst_valid}, {63'd0, exp_inst_valid});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic rv, input logic iv, input logic we, input logic rt);
        exp_req_valid  = rv;
        exp_inst_valid = iv;
        exp_reg_wr_en  = we;
        exp_retire     = rt;
        exp_pc         = m_pc;
        exp_pc2        = m_pc2;
        exp_inst       = m_inst;
        exp_instret    = m_instret;
        exp_halt       = m_halt;
        exp_en         = 1'b1;
    endtask

    // Inputs that the sequencer must ignore in the current cycle
    task automatic junk_inputs();
        imem_req_ready = 1'($urandom);
        imem_rsp_valid = 1'($urandom);
        imem_rsp_data  = $urandom;
        reg_wr_req     = 1'($urandom);
        pc_sel         = 1'($urandom);
        next_pc        = {$urandom, $urandom};
    endtask

    task automatic apply_reset(input int n);
        rstn = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        reg_wr_req = 1'b0; pc_sel = 1'b0; next_pc = '0;
        step();
        m_pc = c_reset_pc; m_pc2 = c_wrap_pc; m_inst = '0; m_instret = '0; m_halt = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < n; i++) step();
        rstn = 1'b1;
    endtask

    task automatic run_inst(input int rdy_dly, input int rsp_dly, input logic [31:0] data,
                            input logic wr, input logic sel, input logic [63:0] npc);
        for (int i = 0; i <= rdy_dly; i++) begin
            step();
            junk_inputs();
            imem_rsp_valid = 1'b0;
            imem_req_ready = (i == rdy_dly);
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i <= rsp_dly; i++) begin
            step();
            junk_inputs();
            imem_rsp_valid = (i == rsp_dly);
            if (i == rsp_dly) imem_rsp_data = data;
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        end
        m_inst = data;
        for (int i = 0; i < 2; i++) begin
            step();
            junk_inputs();
            imem_rsp_valid = 1'b1;
            set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        end
        step();
        junk_inputs();
        reg_wr_req = wr; pc_sel = sel; next_pc = npc;
        set_exp(1'b0, 1'b1, wr && (data != c_ebreak), 1'b1);
        m_instret = m_instret + 64'd1;
        if (sel) begin
            m_pc  = {npc[63:2], 2'b00};
            m_pc2 = {npc[63:2], 2'b00};
        end else begin
            m_pc  = m_pc + 64'd4;
            m_pc2 = m_pc2 + 64'd4;
        end
        if (data == c_ebreak) m_halt = 1'b1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            junk_inputs();
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Request accepted, then reset lands while waiting for the response.
    task automatic fetch_then_reset();
        step();
        junk_inputs(); imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        junk_inputs(); imem_rsp_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        apply_reset(2);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        if (v == c_ebreak) v = v ^ 32'h1;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        apply_reset(2);
        #1;
        check("lit_reset_pc", pc, 64'h0000_0000_8000_0000);
        check("lit_reset_wrap_pc", wrap_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // addi x1,x0,5 with immediate handshake and response
        run_inst(0, 0, c_addi, 1'b1, 1'b0, {$urandom, $urandom});
        #1;
        check("lit_addi_wr_en",  {63'd0, reg_wr_en}, 64'd1);
        check("lit_addi_retire", {63'd0, retire},    64'd1);
        check("lit_model_pc_after_addi", m_pc, 64'h0000_0000_8000_0004);
        check("lit_model_instret",       m_instret, 64'd1);
        check("lit_model_wrap_pc",       m_pc2, 64'd0);

        // Slow ready and slow response
        run_inst(3, 2, 32'h0020_8133, 1'b1, 1'b0, {$urandom, $urandom});
        check("lit_model_pc_before_ebreak", m_pc, 64'h0000_0000_8000_0008);

        // ebreak: no write, then halt for good
        run_inst(0, 0, c_ebreak, 1'b1, 1'b0, {$urandom, $urandom});
        #1;
        check("lit_ebreak_wr_en", {63'd0, reg_wr_en}, 64'd0);
        check("lit_model_halt_pc", m_pc, 64'h0000_0000_8000_000C);
        halt_cycles(20);
        #1;
        check("lit_halt", {63'd0, halt}, 64'd1);
        check("lit_halt_pc", pc, 64'h0000_0000_8000_000C);

        // Reset while halted, then branch redirect with misaligned target
        apply_reset(1);
        run_inst(0, 0, c_addi, 1'b1, 1'b0, {$urandom, $urandom});
        run_inst(1, 1, rand_inst(), 1'($urandom), 1'b1, 64'h0000_0000_8000_0103);
        check("lit_model_branch_pc", m_pc, 64'h0000_0000_8000_0100);
        run_inst(0, 0, rand_inst(), 1'($urandom), 1'b0, {$urandom, $urandom});

        // Reset in WAIT, then random traffic
        fetch_then_reset();
        for (int k = 0; k < 40; k++) begin
            run_inst(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rand_inst(),
                     1'($urandom), ($urandom_range(0, 3) == 0), {$urandom, $urandom});
        end
        run_inst(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), c_ebreak,
                 1'b1, 1'($urandom), {$urandom, $urandom});
        halt_cycles(5);

        step();
        exp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
